calc_core_param: RTL

CALC_CORE_PARAM -- requirements
Module: calc_core_param

---
 rtl/calc_core_param.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/calc_core_param.sv
// Accumulator calculator with flag generation, a bounded undo history and a
// multi-cycle unsigned shift-add multiplier.
module calc_core_param #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           op_valid,
   output logic                           op_ready,
   input  logic [3:0]                     opcode,
   input  logic [WIDTH-1:0]               operand,
   output logic [WIDTH-1:0]               acc,
   output logic [3:0]                     flags,
   output logic                           done,
   output logic                           err,
   output logic [$clog2(DEPTH+1)-1:0]     hist_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = $clog2(WIDTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [NW-1:0] LAST = NW'(WIDTH - 1);

   typedef enum logic {ST_IDLE, ST_MUL} state_t;
   typedef enum logic [3:0] {
      OP_ADD = 4'h0, OP_SUB = 4'h1, OP_OR  = 4'h2, OP_AND = 4'h3,
      OP_XOR = 4'h4, OP_SHL = 4'h5, OP_LSR = 4'h6, OP_ASR = 4'h7,
      OP_NEG = 4'h8, OP_NOT = 4'h9, OP_REV = 4'hA, OP_MUL = 4'hB,
      OP_UNDO = 4'hC, OP_GTU = 4'hD, OP_LTU = 4'hE, OP_EQ = 4'hF
   } op_t;

   state_t             state;
   logic [WIDTH+3:0]   hist [DEPTH];
   logic [WIDTH+3:0]   top_entry;
   logic [WIDTH-1:0]   mcand, prod_hi, prod_lo;
   logic [NW-1:0]      step;
   logic               accept, push;
   logic [WIDTH:0]     sum, diff, add_step;
   logic [WIDTH-1:0]   hi_next, lo_next;
   logic [WIDTH-1:0]   res;
   logic               c_res, v_res;

   assign op_ready  = (state == ST_IDLE);
   assign accept    = op_valid && op_ready;
   assign push      = accept && (opcode != OP_UNDO);
   assign top_entry = hist[IW'(hist_count - 1'b1)];

   assign sum  = {1'b0, acc} + {1'b0, operand};
   assign diff = {1'b0, acc} - {1'b0, operand};

   // One multiplier step: conditionally add the multiplicand to the upper half,
   // then shift the whole {carry, hi, lo} product right by one.
   assign add_step = prod_lo[0] ? ({1'b0, prod_hi} + {1'b0, mcand}) : {1'b0, prod_hi};
   assign hi_next  = add_step[WIDTH:1];
   assign lo_next  = {add_step[0], prod_lo[WIDTH-1:1]};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      res   = acc;
      c_res = 1'b0;
      v_res = 1'b0;
      case (opcode)
         OP_ADD: begin
            res   = sum[WIDTH-1:0];
            c_res = sum[WIDTH];
            v_res = (acc[WIDTH-1] == operand[WIDTH-1]) && (res[WIDTH-1] != acc[WIDTH-1]);
         end
         OP_SUB: begin
            res   = diff[WIDTH-1:0];
            c_res = diff[WIDTH];
            v_res = (acc[WIDTH-1] != operand[WIDTH-1]) && (res[WIDTH-1] != acc[WIDTH-1]);
         end
         OP_OR:  res = acc | operand;
         OP_AND: res = acc & operand;
         OP_XOR: res = acc ^ operand;
         OP_SHL: begin res = {acc[WIDTH-2:0], 1'b0};         c_res = acc[WIDTH-1]; end
         OP_LSR: begin res = {1'b0, acc[WIDTH-1:1]};         c_res = acc[0];       end
         OP_ASR: begin res = {acc[WIDTH-1], acc[WIDTH-1:1]}; c_res = acc[0];       end
         OP_NEG: begin
            res   = -acc;
            v_res = (acc == {1'b1, {(WIDTH-1){1'b0}}});
         end
         OP_NOT: res = ~acc;
         OP_REV: for (int i = 0; i < WIDTH; i++) res[i] = acc[WIDTH-1-i];
         OP_GTU: res = {{(WIDTH-1){1'b0}}, acc > operand};
         OP_LTU: res = {{(WIDTH-1){1'b0}}, acc < operand};
         OP_EQ:  res = {{(WIDTH-1){1'b0}}, acc == operand};
         default: res = acc;
      endcase
   end

   // NOTE: history storage has no reset; hist_count alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         if (hist_count == FULL) begin
            for (int i = 0; i < DEPTH - 1; i++) hist[i] <= hist[i+1];
            hist[DEPTH-1] <= {acc, flags};
         end else begin
            hist[IW'(hist_count)] <= {acc, flags};
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         acc        <= '0;
         flags      <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         hist_count <= '0;
         mcand      <= '0;
         prod_hi    <= '0;
         prod_lo    <= '0;
         step       <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (opcode == OP_MUL) begin
                     state   <= ST_MUL;
                     mcand   <= acc;
                     prod_hi <= '0;
                     prod_lo <= operand;
                     step    <= '0;
                  end else if (opcode == OP_UNDO) begin
                     done <= 1'b1;
                     if (hist_count != '0) begin
                        {acc, flags} <= top_entry;
                        hist_count   <= hist_count - 1'b1;
                     end else begin
                        err <= 1'b1;
                     end
                  end else begin
                     acc   <= res;
                     flags <= {c_res, v_res, res[WIDTH-1], res == '0};
                     done  <= 1'b1;
                  end
                  if (push && hist_count != FULL) hist_count <= hist_count + 1'b1;
               end
            end
            ST_MUL: begin
               prod_hi <= hi_next;
               prod_lo <= lo_next;
               step    <= step + 1'b1;
               if (step == LAST) begin
                  acc   <= lo_next;
                  flags <= {1'b0, hi_next != '0, lo_next[WIDTH-1], lo_next == '0};
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
